// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared constants for the common data bus round-robin arbiter.
// Holds default widths, requester index assignments and the "no tag" value.
package cdb_rr_arbiter_pkg;

    // Default configuration
    localparam int unsigned CDB_N_REQ   = 4;
    localparam int unsigned CDB_DATA_W  = 32;
    localparam int unsigned CDB_LABEL_W = 4;
    localparam int unsigned CDB_IDX_W   = 2;

    // Requester index assignment on the bus
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MUL = 1;
    localparam int unsigned REQ_DIV = 2;
    localparam int unsigned REQ_LS  = 3;

    // Tag value reserved for "no reservation station"
    localparam int unsigned NO_TAG = 0;

    // Width of the optional performance counters
    localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/cdb_rr_arbiter_pick.sv
// Combinational rotate-priority encoder.
// Scans req starting at ptr and wrapping; returns the first set index.
// Ports:
//   req         : request vector
//   ptr         : index with highest priority this cycle
//   grant_c     : one-hot grant (all-zero when nothing requests)
//   grant_idx_c : index of the granted requester (0 when none)
//   any_c       : at least one requester is set
module rr_pick
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = CDB_N_REQ,
    parameter int unsigned IDX_W = CDB_IDX_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [IDX_W-1:0] grant_idx_c,
    output logic             any_c
);

    logic [IDX_W-1:0] sel_c;

    // First hit in rotated order wins; later hits are ignored via any_c
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        sel_c       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sel_c = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!any_c && req[sel_c]) begin
                grant_c[sel_c] = 1'b1;
                grant_idx_c    = sel_c;
                any_c          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter and registered broadcast stage for the common data bus.
// Accepts at most one result per cycle and rebroadcasts it one cycle later.
// Optional feature macro: CDB_PERF_CNT_EN adds per-requester accept counters
// (bcCount) and a stall counter (stallCount).
// Ports:
//   clk, nRST   : clock (rising edge), asynchronous active-low reset
//   require     : per-requester valid
//   dataIn      : flattened result data, slice i for requester i
//   labelIn     : flattened result tags, slice i for requester i
//   requireAC   : one-hot accept, combinational, zero during reset
//   BCEN        : broadcast valid
//   BCdata      : broadcast data
//   BClabel     : broadcast tag
//   BCsrc       : broadcast requester index
//   tagErr      : sticky, set when a tag-0 result was accepted
//   bcCount     : (optional) per-requester accepted-result counters
//   stallCount  : (optional) cycles with an eligible but ungranted requester
module cdb_rr_arbiter
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = CDB_N_REQ,
    parameter int unsigned DATA_W  = CDB_DATA_W,
    parameter int unsigned LABEL_W = CDB_LABEL_W,
    parameter int unsigned IDX_W   = CDB_IDX_W
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [N_REQ-1:0]         require,
    input  logic [N_REQ*DATA_W-1:0]  dataIn,
    input  logic [N_REQ*LABEL_W-1:0] labelIn,
    output logic [N_REQ-1:0]         requireAC,
    output logic                     BCEN,
    output logic [DATA_W-1:0]        BCdata,
    output logic [LABEL_W-1:0]       BClabel,
    output logic [IDX_W-1:0]         BCsrc,
    output logic                     tagErr
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [N_REQ*CNT_W-1:0]   bcCount,
    output logic [CNT_W-1:0]         stallCount
`endif
);

    logic [IDX_W-1:0]   ptr;
    logic [N_REQ-1:0]   grant_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic               any_c;
    logic [IDX_W-1:0]   ptr_next_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic [LABEL_W-1:0] sel_label_c;
    logic               tag_zero_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (require),
        .ptr         (ptr),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_c       (any_c)
    );

    // Accept is suppressed while reset is held
    assign requireAC = nRST ? grant_c : '0;

    // One-hot mux of the granted requester's payload
    always_comb begin
        sel_data_c  = '0;
        sel_label_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                sel_data_c  = dataIn[i*DATA_W +: DATA_W];
                sel_label_c = labelIn[i*LABEL_W +: LABEL_W];
            end
        end
    end

    assign tag_zero_c = (sel_label_c == LABEL_W'(NO_TAG));

    // Priority moves just past the winner, wrapping after the last requester
    assign ptr_next_c = (grant_idx_c == IDX_W'(N_REQ - 1)) ? '0
                                                           : grant_idx_c + IDX_W'(1);

    // Pointer and broadcast register; payload holds when nothing is broadcast
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr     <= '0;
            BCEN    <= 1'b0;
            BCdata  <= '0;
            BClabel <= '0;
            BCsrc   <= '0;
            tagErr  <= 1'b0;
        end else begin
            BCEN <= 1'b0;
            if (any_c) begin
                ptr <= ptr_next_c;
                if (tag_zero_c) begin
                    // Accepted to free the requester, but never put on the bus
                    tagErr <= 1'b1;
                end else begin
                    BCEN    <= 1'b1;
                    BCdata  <= sel_data_c;
                    BClabel <= sel_label_c;
                    BCsrc   <= grant_idx_c;
                end
            end
        end
    end

`ifdef CDB_PERF_CNT_EN
    // Accept counters per requester and cycles where someone was left waiting
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bcCount    <= '0;
            stallCount <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant_c[i]) begin
                    bcCount[i*CNT_W +: CNT_W] <= bcCount[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            if (|(require & ~grant_c)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
        end
    end
`endif

endmodule
